instr_fetch_unit: RTL and testbench

Initiator side of the program-memory read interface. It owns the program counter and drives the 5-bit read address. Each cycle it captures the returned 6-bit instruction word into an instruction register and splits it into opcode and register-select fields for the datapath. It also handles start, stall, jump, halt and end-of-program, and keeps a count of issued instructions.

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the program-memory
// read address, captures the returned word into the instruction register and
// exposes its opcode / register-select fields. A three-state FSM (idle, run,
// done) sequences start, stall, jump, halt and end-of-program handling, and a
// saturating counter tracks how many instructions have been issued.
module instr_fetch_unit #(
  parameter int ADDR_W    = 5,
  parameter int INS_W     = 6,
  parameter int OPC_W     = 4,
  parameter int REG_W     = 2,
  parameter int LAST_ADDR = 31,
  parameter int WRAP      = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  input  logic [INS_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INS_W-1:0]  ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  reg_sel,
  output logic              ins_valid,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  ins_count
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] pc_zero = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] pc_one  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] pc_last = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0]  cnt_max = {CNT_W{1'b1}};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic [INS_W-1:0]    ir_r, ir_s;
  logic                valid_r, valid_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == cnt_max) begin
      result = cnt_max;
    end else begin
      result = value + cnt_one;
    end
    return result;
  endfunction

  // Next-state logic: FSM transitions plus PC / IR / counter updates.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    valid_s = 1'b0;
    cnt_s   = cnt_r;
    case (state_r)
      st_idle: begin
        // PC is pinned to 0; the start edge itself does not fetch.
        pc_s = pc_zero;
        if (start) begin
          state_s = st_run;
        end else begin
          state_s = st_idle;
        end
      end
      st_run: begin
        if (halt) begin
          state_s = st_done;
        end else if (jump_en) begin
          // Word at the old PC is dropped; the jump wins over stall.
          pc_s = jump_addr;
        end else if (stall) begin
          pc_s = pc_r;
        end else begin
          ir_s    = mem_data;
          valid_s = 1'b1;
          cnt_s   = sat_inc(cnt_r);
          if (pc_r == pc_last) begin
            if (WRAP != 0) begin
              pc_s = pc_zero;
            end else begin
              pc_s    = pc_r;
              state_s = st_done;
            end
          end else begin
            // Targets beyond the last address count up modulo 2^ADDR_W.
            pc_s = pc_r + pc_one;
          end
        end
      end
      st_done: begin
        // Terminal until reset; start is ignored here.
        state_s = st_done;
      end
      default: begin
        state_s = st_idle;
        pc_s    = pc_zero;
      end
    endcase
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
      pc_r    <= pc_zero;
      ir_r    <= {INS_W{1'b0}};
      valid_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      valid_r <= valid_s;
      cnt_r   <= cnt_s;
    end
  end

  assign mem_addr  = pc_r;
  assign ir        = ir_r;
  assign opcode    = ir_r[INS_W-1:REG_W];
  assign reg_sel   = ir_r[REG_W-1:0];
  assign ins_valid = valid_r;
  assign ins_count = cnt_r;
  assign running   = (state_r == st_run);
  assign done      = (state_r == st_done);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Instance a: LAST_ADDR=16, no wrap.
// Instance b: LAST_ADDR=3, wrapping, used for the wrap and saturation cases.
module tb_instr_fetch_unit;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h8;

  typedef struct packed {
    logic [5:0] ir;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] mem [32];

  // shared control inputs (instance b only sees them at zero)
  logic       stall, jump_en, halt;
  logic [4:0] jump_addr;

  logic       rst_a, start_a, valid_a, running_a, done_a;
  logic [4:0] addr_a;
  logic [5:0] data_a, ir_a;
  logic [3:0] opc_a;
  logic [1:0] reg_a;
  logic [7:0] cnt_a;

  logic       rst_b, start_b, valid_b, running_b, done_b;
  logic [4:0] addr_b;
  logic [5:0] data_b, ir_b;
  logic [3:0] opc_b;
  logic [1:0] reg_b;
  logic [7:0] cnt_b;

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

  instr_fetch_unit #(.LAST_ADDR(16), .WRAP(0)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stall(stall), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt), .mem_data(data_a), .mem_addr(addr_a),
    .ir(ir_a), .opcode(opc_a), .reg_sel(reg_a), .ins_valid(valid_a),
    .running(running_a), .done(done_a), .ins_count(cnt_a)
  );

  instr_fetch_unit #(.LAST_ADDR(3), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stall(stall), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt), .mem_data(data_b), .mem_addr(addr_b),
    .ir(ir_b), .opcode(opc_b), .reg_sel(reg_b), .ins_valid(valid_b),
    .running(running_b), .done(done_b), .ins_count(cnt_b)
  );

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_state_a(input string name, input int addr, input logic [5:0] irv,
                             input logic v, input int cnt, input logic run, input logic dn);
    chk({name, "_addr"}, addr_a, addr);
    chk({name, "_ir"}, ir_a, irv);
    chk({name, "_valid"}, valid_a, v);
    chk({name, "_count"}, cnt_a, cnt);
    chk({name, "_running"}, running_a, run);
    chk({name, "_done"}, done_a, dn);
  endtask

  // One normal fetch cycle on instance a: expected issue goes to the scoreboard.
  task automatic issue(input int addr, input int cnt);
    chk("a_issue_addr", addr_a, addr);
    qa.push_back(exp_t'{ir: mem[addr], cnt: 8'(cnt)});
    start_a = 1'b0; stall = 1'b0; jump_en = 1'b0; halt = 1'b0;
    @(negedge clk);
  endtask

  // monitor for instance a
  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_issue", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_ir", ir_a, ea.ir);
        chk("a_fields", {opc_a, reg_a}, ea.ir);
        chk("a_count", cnt_a, ea.cnt);
      end
    end
  end

  // monitor for instance b
  always @(negedge clk) begin
    if (valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_issue", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_ir", ir_b, eb.ir);
        chk("b_fields", {opc_b, reg_b}, eb.ir);
        chk("b_count", cnt_b, eb.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 6'((i * 7 + 3) & 63);
    mem[0]  = {OP_ADD, 2'd1};
    mem[1]  = {OP_SUB, 2'd1};
    mem[14] = {OP_LD, 2'd2};
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    stall = 1'b0; jump_en = 1'b0; halt = 1'b0; jump_addr = 5'd0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    chk_state_a("reset", 0, 6'd0, 1'b0, 0, 1'b0, 1'b0);

    // phase 1: halt in idle, start, stall, jump with stall, end of program
    halt = 1'b1; @(negedge clk); halt = 1'b0;
    chk_state_a("idle_halt", 0, 6'd0, 1'b0, 0, 1'b0, 1'b0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk_state_a("start", 0, 6'd0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) issue(i, i + 1);
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; @(negedge clk);
      chk_state_a("stall", 5, mem[4], 1'b0, 5, 1'b1, 1'b0);
    end
    stall = 1'b0;
    for (int i = 5; i < 8; i++) issue(i, i + 1);
    jump_en = 1'b1; stall = 1'b1; jump_addr = 5'd14; @(negedge clk);
    jump_en = 1'b0; stall = 1'b0;
    chk_state_a("jump", 14, mem[7], 1'b0, 8, 1'b1, 1'b0);
    issue(14, 9);
    chk("ld_opcode", opc_a, OP_LD);
    chk("ld_reg_sel", reg_a, 2'd2);
    issue(15, 10);
    issue(16, 11);
    chk_state_a("last_issue", 16, mem[16], 1'b1, 11, 1'b0, 1'b1);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk_state_a("done_start", 16, mem[16], 1'b0, 11, 1'b0, 1'b1);

    // phase 2: clean run 0..16 gives 17 issues
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    chk_state_a("rst_from_done", 0, 6'd0, 1'b0, 0, 1'b0, 1'b0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i <= 16; i++) issue(i, i + 1);
    chk_state_a("run17", 16, mem[16], 1'b1, 17, 1'b0, 1'b1);
    @(negedge clk);
    chk_state_a("run17_after", 16, mem[16], 1'b0, 17, 1'b0, 1'b1);

    // phase 3: reset mid-run, halt in idle, jump past last address, halt in run
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 9; i++) issue(i, i + 1);
    chk("pre_rst_addr", addr_a, 5'd9);
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    chk_state_a("rst_mid", 0, 6'd0, 1'b0, 0, 1'b0, 1'b0);
    halt = 1'b1; @(negedge clk); halt = 1'b0;
    chk_state_a("idle_halt2", 0, 6'd0, 1'b0, 0, 1'b0, 1'b0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    issue(0, 1);
    jump_en = 1'b1; jump_addr = 5'd30; @(negedge clk); jump_en = 1'b0;
    chk_state_a("jump_hi", 30, mem[0], 1'b0, 1, 1'b1, 1'b0);
    issue(30, 2);
    issue(31, 3);
    issue(0, 4);
    halt = 1'b1; @(negedge clk); halt = 1'b0;
    chk_state_a("halt", 1, mem[0], 1'b0, 4, 1'b0, 1'b1);
    @(negedge clk);
    chk_state_a("halt_hold", 1, mem[0], 1'b0, 4, 1'b0, 1'b1);

    // instance b: wrapping address sequence and counter saturation
    rst_b = 1'b0; @(negedge clk);
    chk("b_reset_count", cnt_b, 8'd0);
    chk("b_reset_running", running_b, 1'b0);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    chk("b_running", running_b, 1'b1);
    for (int k = 0; k < 260; k++) begin
      chk("b_addr", addr_b, k % 4);
      qb.push_back(exp_t'{ir: mem[k % 4], cnt: (k + 1 > 255) ? 8'd255 : 8'(k + 1)});
      @(negedge clk);
    end
    chk("b_still_running", running_b, 1'b1);
    rst_b = 1'b1; @(negedge clk);
    chk("b_rst_valid", valid_b, 1'b0);
    chk("b_rst_count", cnt_b, 8'd0);

    @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
